// File: rtl/sha1_padder.sv
// SHA-1 message pre-processor: packs a byte stream big-endian into 512-bit blocks,
// appends 0x80 / zero fill / 64-bit bit length, and hands blocks to the core one at a time.
module sha1_padder #(
    parameter int LEN_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_empty,
    output logic              in_ready,
    output logic [15:0][31:0] blk_data,
    output logic              blk_start,
    output logic              blk_first,
    output logic              blk_last,
    input  logic              core_done,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, ABSORB, PAD, EMIT, WAIT, EXTRA} state_t;

    state_t             r_state;
    logic [5:0]         r_idx;
    logic [LEN_W-1:0]   r_len;
    logic [15:0][31:0]  r_buf;
    logic               r_first;
    logic               r_last;
    logic               r_pend;
    logic               r_padq;
    logic               r_ready;
    logic               r_start;
    logic               r_blk_first;
    logic               r_blk_last;
    logic               r_busy;

    logic               w_xfer;
    logic [63:0]        w_len64;

    assign w_xfer  = in_valid & r_ready;
    assign w_len64 = 64'(r_len);

    assign in_ready  = r_ready;
    assign blk_data  = r_buf;
    assign blk_start = r_start;
    assign blk_first = r_blk_first;
    assign blk_last  = r_blk_last;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_buf       <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_pend      <= 1'b0;
            r_padq      <= 1'b0;
            r_ready     <= 1'b1;
            r_start     <= 1'b0;
            r_blk_first <= 1'b0;
            r_blk_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_start <= 1'b0;

            if (w_xfer) begin
                r_buf[r_idx[5:2]][{~r_idx[1:0], 3'b000} +: 8] <= in_byte;
                r_idx <= r_idx + 6'd1;
                r_len <= r_len + LEN_W'(8);
            end

            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_busy  <= 1'b1;
                        r_first <= 1'b1;
                        if (in_last) begin
                            r_state <= PAD;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= ABSORB;
                        end
                    end else if (in_empty) begin
                        r_busy  <= 1'b1;
                        r_first <= 1'b1;
                        r_state <= PAD;
                        r_ready <= 1'b0;
                    end
                end

                ABSORB: begin
                    if (w_xfer) begin
                        // A full data block must go out before any padding; a last
                        // byte landing at 63 queues a padding-only block behind it.
                        if (r_idx == 6'd63) begin
                            r_state     <= EMIT;
                            r_ready     <= 1'b0;
                            r_start     <= 1'b1;
                            r_blk_first <= r_first;
                            r_blk_last  <= 1'b0;
                            r_padq      <= in_last;
                        end else if (in_last) begin
                            r_state <= PAD;
                            r_ready <= 1'b0;
                        end
                    end
                end

                PAD: begin
                    for (int b = 0; b < 64; b++) begin
                        if (6'(b) == r_idx)
                            r_buf[4'(b / 4)][5'(8 * (3 - b % 4)) +: 8] <= 8'h80;
                        else if (6'(b) > r_idx)
                            r_buf[4'(b / 4)][5'(8 * (3 - b % 4)) +: 8] <= 8'h00;
                        if (b >= 56 && r_idx <= 6'd55)
                            r_buf[4'(b / 4)][5'(8 * (3 - b % 4)) +: 8] <= w_len64[6'(8 * (63 - b)) +: 8];
                    end
                    r_last      <= (r_idx <= 6'd55);
                    r_pend      <= (r_idx > 6'd55);
                    r_padq      <= 1'b0;
                    r_state     <= EMIT;
                    r_start     <= 1'b1;
                    r_blk_first <= r_first;
                    r_blk_last  <= (r_idx <= 6'd55);
                end

                EMIT: begin
                    r_first <= 1'b0;
                    r_state <= WAIT;
                end

                WAIT: begin
                    if (core_done) begin
                        r_blk_first <= 1'b0;
                        r_blk_last  <= 1'b0;
                        if (r_last) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_len   <= '0;
                            r_idx   <= '0;
                            r_last  <= 1'b0;
                            r_ready <= 1'b1;
                        end else if (r_pend) begin
                            r_state <= EXTRA;
                        end else if (r_padq) begin
                            r_state <= PAD;
                            r_idx   <= '0;
                        end else begin
                            r_state <= ABSORB;
                            r_idx   <= '0;
                            r_ready <= 1'b1;
                        end
                    end
                end

                EXTRA: begin
                    for (int b = 0; b < 64; b++) begin
                        if (b < 56)
                            r_buf[4'(b / 4)][5'(8 * (3 - b % 4)) +: 8] <= 8'h00;
                        else
                            r_buf[4'(b / 4)][5'(8 * (3 - b % 4)) +: 8] <= w_len64[6'(8 * (63 - b)) +: 8];
                    end
                    r_last      <= 1'b1;
                    r_pend      <= 1'b0;
                    r_state     <= EMIT;
                    r_start     <= 1'b1;
                    r_blk_first <= r_first;
                    r_blk_last  <= 1'b1;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// Directed bench for sha1_padder: a reference padder fills a block scoreboard,
// a core model answers each blk_start with core_done after a programmable delay.
module tb_sha1_padder;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_last;
    logic              in_empty;
    logic              in_ready;
    logic [15:0][31:0] blk_data;
    logic              blk_start;
    logic              blk_first;
    logic              blk_last;
    logic              core_done;
    logic              busy;

    typedef struct {
        logic [15:0][31:0] d;
        logic              f;
        logic              l;
    } exp_t;

    exp_t              sb[$];
    logic [15:0][31:0] lastblk;
    int                checks = 0;
    int                errors = 0;
    int                done_dly = 3;

    sha1_padder #(.LEN_W(64)) dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_empty(in_empty), .in_ready(in_ready),
        .blk_data(blk_data), .blk_start(blk_start), .blk_first(blk_first),
        .blk_last(blk_last), .core_done(core_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference SHA-1 padding of a whole message, split into expected blocks.
    task automatic push_expected(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          nblk;
        exp_t        e;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nblk = p.size() / 64;
        for (int bk = 0; bk < nblk; bk++) begin
            for (int w = 0; w < 16; w++)
                e.d[w] = {p[64*bk+4*w], p[64*bk+4*w+1], p[64*bk+4*w+2], p[64*bk+4*w+3]};
            e.f = (bk == 0);
            e.l = (bk == nblk - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        in_byte  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("send_timeout", 64'(n), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        for (int i = 0; i < msg.size(); i++) send(msg[i], i == msg.size() - 1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < 3000), 64'd1);
    endtask

    // Block scoreboard: every blk_start must match the oldest expected block.
    always @(negedge clk) begin
        if (blk_start) begin
            if (sb.size() == 0) begin
                chk("unexpected_start", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int w = 0; w < 16; w++)
                    chk($sformatf("blk_w%0d", w), 64'(blk_data[w]), 64'(e.d[w]));
                chk("blk_first", 64'(blk_first), 64'(e.f));
                chk("blk_last", 64'(blk_last), 64'(e.l));
                lastblk = blk_data;
            end
        end
    end

    // Core model: done pulse done_dly cycles after each start.
    initial begin
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (blk_start) begin
                repeat (done_dly) @(negedge clk);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] m[$];
        reset = 1'b1; in_byte = '0; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_start", 64'(blk_start), 64'd0);
        chk("rst_first", 64'(blk_first), 64'd0);
        chk("rst_last", 64'(blk_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(blk_data == '0), 64'd1);

        // "abc" with start latency of two cycles after the last byte
        m = '{8'h61, 8'h62, 8'h63};
        push_expected(m);
        send_msg(m);
        chk("abc_lat_pad", 64'(blk_start), 64'd0);
        @(negedge clk);
        chk("abc_lat_emit", 64'(blk_start), 64'd1);
        drain("abc_drain");
        chk("abc_w0", 64'(lastblk[0]), 64'h61626380);
        chk("abc_w15", 64'(lastblk[15]), 64'h18);

        // zero-length message
        m = {};
        push_expected(m);
        in_empty = 1'b1;
        @(negedge clk);
        in_empty = 1'b0;
        drain("empty_drain");
        chk("empty_w0", 64'(lastblk[0]), 64'h80000000);

        // 55 zero bytes: padding and length fit in one block
        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'h00);
        push_expected(m);
        send_msg(m);
        drain("b55_drain");
        chk("b55_w13", 64'(lastblk[13]), 64'h00000080);
        chk("b55_w15", 64'(lastblk[15]), 64'h1B8);

        // 56 bytes of 0xFF: length spills into a second block
        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'hFF);
        push_expected(m);
        send_msg(m);
        drain("b56_drain");
        chk("b56_w15", 64'(lastblk[15]), 64'h1C0);

        // 64 bytes with a slow core: backpressure while waiting
        done_dly = 20;
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i + 1));
        push_expected(m);
        send_msg(m);
        chk("b64_start", 64'(blk_start), 64'd1);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            chk("b64_hold_ready", 64'(in_ready), 64'd0);
            chk("b64_hold_start", 64'(blk_start), 64'd0);
        end
        drain("b64_drain");
        chk("b64_w0", 64'(lastblk[0]), 64'h80000000);
        chk("b64_w15", 64'(lastblk[15]), 64'h200);
        done_dly = 3;

        // reset mid-message aborts without a block
        for (int i = 0; i < 10; i++) send(8'hA5, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_start", 64'(blk_start), 64'd0);
        repeat (5) @(negedge clk);

        m = '{8'h61, 8'h62, 8'h63};
        push_expected(m);
        send_msg(m);
        drain("abc2_drain");
        chk("abc2_w0", 64'(lastblk[0]), 64'h61626380);
        chk("abc2_w15", 64'(lastblk[15]), 64'h18);

        repeat (30) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha1_padder.md
Name: sha1_padder

Overview:
- Message pre-processor that sits directly upstream of the sha_1 core.
- Accepts an arbitrary-length byte stream over a valid/ready handshake and packs it big-endian into 16x32-bit blocks.
- Appends the SHA-1 padding (0x80, zero fill, 64-bit big-endian bit length).
- Presents each 512-bit block to the core's in_data with a one-cycle start pulse, then waits for the core's done before building the next block.

Parameters:
LEN_W, 64, width of message bit-length counter; length field is always 64 bits, zero-extended if LEN_W<64.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_byte  input  8  message byte
in_valid  input  1  in_byte valid
in_last  input  1  qualified by in_valid; marks final byte of message
in_empty  input  1  one-cycle pulse while idle; hash a zero-length message
in_ready  output  1  padder accepts in_byte this cycle
blk_data  output  16x32  block words; blk_data[0] = first word, byte 0 in bits [31:24]
blk_start  output  1  one-cycle pulse; connects to core start
blk_first  output  1  block is first of message (core reloads initial H)
blk_last  output  1  block is final of message (core result valid after its done)
core_done  input  1  core finished current block
busy  output  1  message in progress

Behaviour:
- Reset (synchronous, active-high): state=IDLE; byte index=0; length=0; block buffer zeroed. Outputs: in_ready=1, blk_start=0, blk_first=0, blk_last=0, busy=0, blk_data=0.
- Reset mid-operation aborts the message; no further blk_start is issued.
- Byte transfer occurs when in_valid & in_ready. in_ready=1 only in IDLE and ABSORB.
- Each transfer:
  - writes byte to buffer position idx (word idx/4, bits 31-8*(idx%4) downto 24-8*(idx%4));
  - idx+=1 (6-bit, wraps 63->0);
  - length+=8, wrapping mod 2^LEN_W.
- FSM states: IDLE, ABSORB, PAD, EMIT, WAIT, EXTRA.
- IDLE:
  - first transfer -> ABSORB, busy=1, first_flag=1;
  - in_empty pulse -> PAD with idx=0;
  - in_empty together with in_valid: byte wins, in_empty ignored.
- ABSORB:
  - transfer with idx==63 and not in_last -> EMIT (blk_last=0);
  - transfer with in_last -> PAD.
- PAD (1 cycle):
  - writes 0x80 at idx and clears bytes idx+1..63;
  - if idx<=55: writes length into bytes 56..63 (word14=high, word15=low), sets last_flag=1 -> EMIT;
  - else: last_flag=0, pending_len=1 -> EMIT.
- EMIT (1 cycle):
  - blk_start=1, blk_first=first_flag, blk_last=last_flag; blk_data stable from this cycle until core_done is seen;
  - clears first_flag -> WAIT.
- WAIT:
  - core_done sampled from the cycle after blk_start; done in the EMIT cycle is ignored.
  - On core_done: if last_flag -> IDLE (busy=0, length=0, idx=0); elif pending_len -> EXTRA; else -> ABSORB with idx=0.
  - in_ready=0 throughout (backpressure).
- EXTRA (1 cycle): buffer bytes 0..55 zeroed, bytes 56..63 = length, last_flag=1, pending_len=0 -> EMIT.
- Latency:
  - 64th byte accepted -> blk_start on next cycle;
  - in_last accepted -> blk_start 2 cycles later (PAD, EMIT);
  - core_done -> next byte accepted next cycle.
- blk_first/blk_last: valid for the whole EMIT..WAIT interval; blk_start is the only pulse.
- in_last on byte 63 (idx==63): PAD with idx=0 after wrap. This gives the full 0x80/zeros/length block as a separate block (message length multiple of 64).

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one blk_start, blk_first=blk_last=1; word0=0x61626380, words1-14=0, word15=0x00000018.
- in_empty pulse in IDLE -> one block, word0=0x80000000, words1-15=0, blk_first=blk_last=1.
- 55 bytes of 0x00 -> one block, byte55=0x80, word15=0x000001B8.
- 56 bytes of 0xFF -> two blocks:
  - block1: bytes 0-55=0xFF, byte56=0x80, rest 0, blk_last=0;
  - block2: zeros, word15=0x000001C0, blk_first=0, blk_last=1.
- 64 bytes, core_done held low 20 cycles after first start -> in_ready=0 for those 20 cycles, no second start. After done: second block word0=0x80000000, word15=0x00000200.
- Reset asserted after 10 bytes -> next cycle busy=0, in_ready=1, no blk_start. Subsequent "abc" yields the first test's block exactly.
